core_fetch_bus: RTL and testbench

CORE_FETCH_BUS -- requirements
Module: core_fetch_bus

---
 rtl/core_fetch_bus.sv | 128 ++++++++++++
 tb/tb_core_fetch_bus.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/core_fetch_bus.sv
// Instruction fetch bus master: one outstanding word read, flush/redirect with discard of in-flight data.
// Optional fault reporting (insn_fault / fetch_fault / HALT state) is enabled by defining CORE_FETCH_FAULT_EN.
module core_fetch_bus #(
    parameter logic [29:0] RESET_PC = 30'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        flush,
    input  logic [29:0] target,
    input  logic        insn_ready,
    input  logic [31:0] insn_data,
`ifdef CORE_FETCH_FAULT_EN
    input  logic        insn_fault,
    output logic        fetch_fault,
`endif
    output logic        insn_start,
    output logic [29:0] insn_addr,
    output logic        fetched,
    output logic [31:0] fetch_data
);

`ifdef CORE_FETCH_FAULT_EN
    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;
    logic fault_q;
`else
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
`endif

    state_t      state;
    logic [29:0] pc;
    logic [29:0] req_addr;
    logic [29:0] pc_inc;
    logic        fetched_q;
    logic [31:0] data_q;

    assign pc_inc     = pc + 30'd1;
    assign insn_start = (state == REQ) || (state == DISCARD);
    assign insn_addr  = req_addr;
    assign fetched    = fetched_q;
    assign fetch_data = data_q;
`ifdef CORE_FETCH_FAULT_EN
    assign fetch_fault = fault_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            fetched_q <= 1'b0;
            data_q    <= 32'h0;
`ifdef CORE_FETCH_FAULT_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            // Only a clean completion in REQ raises fetched_q; every other edge drops it.
            fetched_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        pc <= target;
                    end else if (fetch) begin
                        state    <= REQ;
                        req_addr <= pc;
                    end
                end
                REQ: begin
                    if (flush) begin
                        pc <= target;
                        if (insn_ready) begin
                            if (fetch) begin
                                req_addr <= target;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (insn_ready) begin
`ifdef CORE_FETCH_FAULT_EN
                        if (insn_fault) begin
                            fault_q <= 1'b1;
                            state   <= HALT;
                        end else begin
`else
                        begin
`endif
                            data_q    <= insn_data;
                            fetched_q <= 1'b1;
                            pc        <= pc_inc;
                            if (fetch) begin
                                req_addr <= pc_inc;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                DISCARD: begin
                    // The abandoned read must still finish on the bus; its data is dropped.
                    if (flush) begin
                        pc <= target;
                    end
                    if (insn_ready) begin
                        if (fetch && !flush) begin
                            state    <= REQ;
                            req_addr <= pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
`ifdef CORE_FETCH_FAULT_EN
                HALT: begin
                    if (flush) begin
                        fault_q <= 1'b0;
                        pc      <= target;
                        state   <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_fetch_bus.sv
// Directed bench for core_fetch_bus: driver pushes expected fetch_data into a queue,
// a negedge monitor pops and compares whenever fetched=1.
module tb_core_fetch_bus;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch, flush, insn_ready;
    logic [29:0] target;
    logic [31:0] insn_data;
    logic        insn_start, fetched;
    logic [29:0] insn_addr;
    logic [31:0] fetch_data;
`ifdef CORE_FETCH_FAULT_EN
    logic        insn_fault;
    logic        fetch_fault;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    core_fetch_bus #(.RESET_PC(30'd0)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .flush(flush), .target(target),
        .insn_ready(insn_ready), .insn_data(insn_data),
`ifdef CORE_FETCH_FAULT_EN
        .insn_fault(insn_fault), .fetch_fault(fetch_fault),
`endif
        .insn_start(insn_start), .insn_addr(insn_addr),
        .fetched(fetched), .fetch_data(fetch_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every fetched pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && fetched) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_fetch: got %h expected no response at %0t", fetch_data, $time);
            end else begin
                chk("fetch_data", fetch_data, exp_q.pop_front());
            end
        end
    end

    // Check current outputs at the negedge, then drive inputs for the next rising edge.
    task automatic step(input logic f, input logic fl, input logic [29:0] tg, input logic rdy,
                        input logic [31:0] d, input logic es, input logic [29:0] ea,
                        input logic push, input logic ft = 1'b0);
        @(negedge clk);
        chk("insn_start", {31'd0, insn_start}, {31'd0, es});
        if (es) chk("insn_addr", {2'd0, insn_addr}, {2'd0, ea});
        fetch = f; flush = fl; target = tg; insn_ready = rdy; insn_data = d;
`ifdef CORE_FETCH_FAULT_EN
        insn_fault = ft;
`else
        if (ft) $display("note: fault stimulus ignored in this build");
`endif
        if (push) exp_q.push_back(d);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        fetch = 1'b0; flush = 1'b0; insn_ready = 1'b0; target = 30'd0; insn_data = 32'd0;
        #1;
        chk("rst_insn_start", {31'd0, insn_start}, 32'd0);
        chk("rst_fetched", {31'd0, fetched}, 32'd0);
        chk("rst_insn_addr", {2'd0, insn_addr}, 32'd0);
        chk("rst_fetch_data", fetch_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; fetch = 1'b0; flush = 1'b0; insn_ready = 1'b0;
        target = 30'd0; insn_data = 32'd0;
`ifdef CORE_FETCH_FAULT_EN
        insn_fault = 1'b0;
`endif
        #1;
        chk("por_insn_start", {31'd0, insn_start}, 32'd0);
        chk("por_fetched", {31'd0, fetched}, 32'd0);
        chk("por_insn_addr", {2'd0, insn_addr}, 32'd0);
        chk("por_fetch_data", fetch_data, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Back-to-back streaming, addresses 0,1,2,3; last read completes with fetch=0.
        step(1, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0, 1, 32'hA000_0000, 1, 30'd0, 1);
        step(1, 0, 30'd0, 1, 32'hA000_0001, 1, 30'd1, 1);
        step(1, 0, 30'd0, 1, 32'hA000_0002, 1, 30'd2, 1);
        step(0, 0, 30'd0, 1, 32'hA000_0003, 1, 30'd3, 1);
        step(0, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);

        // Wait states: address held stable for three cycles, one pulse.
        pulse_reset();
        step(1, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0, 0, 32'h0,         1, 30'd0, 0);
        step(1, 0, 30'd0, 0, 32'h0,         1, 30'd0, 0);
        step(0, 0, 30'd0, 1, 32'hB000_0000, 1, 30'd0, 1);
        step(0, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);
        step(0, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);

        // Flush while read to 5 outstanding: DEADBEEF dropped, next read at 0x100.
        step(0, 1, 30'd5,     0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0,     0, 32'h0,         0, 30'd0, 0);
        step(1, 1, 30'h100,   0, 32'h0,         1, 30'd5, 0);
        step(1, 0, 30'd0,     0, 32'h0,         1, 30'd5, 0);
        step(1, 0, 30'd0,     1, 32'hDEAD_BEEF, 1, 30'd5, 0);
        step(0, 0, 30'd0,     1, 32'hC000_0100, 1, 30'h100, 1);

        // Flush coinciding with ready: data dropped, redirect straight to 0x40.
        step(1, 0, 30'd0,  0, 32'h0,         0, 30'd0, 0);
        step(1, 1, 30'h40, 1, 32'h1111_1111, 1, 30'h101, 0);
        step(0, 0, 30'd0,  1, 32'hD000_0040, 1, 30'h40, 1);

        // Address wrap at the top of the 30-bit space.
        step(0, 1, 30'h3FFF_FFFF, 0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0,         0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0,         1, 32'hE000_0000, 1, 30'h3FFF_FFFF, 1);
        step(0, 0, 30'd0,         1, 32'hE000_0001, 1, 30'd0, 1);

        // Reset in the middle of REQ, then restart at RESET_PC.
        step(1, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0, 1, 32'hF000_0001, 1, 30'd1, 1);
        step(1, 0, 30'd0, 0, 32'h0,         1, 30'd2, 0);
        pulse_reset();
        step(1, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);
        step(0, 0, 30'd0, 1, 32'hF100_0000, 1, 30'd0, 1);

        // Reset during DISCARD: a late ready must produce nothing.
        step(1, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);
        step(1, 1, 30'd9, 0, 32'h0,         1, 30'd1, 0);
        pulse_reset();
        step(0, 0, 30'd0, 1, 32'h2222_2222, 0, 30'd0, 0);
        step(0, 0, 30'd0, 0, 32'h0,         0, 30'd0, 0);

`ifdef CORE_FETCH_FAULT_EN
        // Faulted read at 7 halts until a flush redirects to 0x20.
        step(0, 1, 30'd7,  0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0,  0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0,  1, 32'h3333_3333, 1, 30'd7, 0, 1'b1);
        chk("fault_clear_before", {31'd0, fetch_fault}, 32'd0);
        step(1, 0, 30'd0,  0, 32'h0,         0, 30'd0, 0);
        chk("fetch_fault_set", {31'd0, fetch_fault}, 32'd1);
        step(1, 0, 30'd0,  0, 32'h0,         0, 30'd0, 0);
        step(0, 1, 30'h20, 0, 32'h0,         0, 30'd0, 0);
        step(1, 0, 30'd0,  0, 32'h0,         0, 30'd0, 0);
        chk("fetch_fault_cleared", {31'd0, fetch_fault}, 32'd0);
        step(0, 0, 30'd0,  1, 32'h4400_0020, 1, 30'h20, 1);
`endif

        step(0, 0, 30'd0, 0, 32'h0, 0, 30'd0, 0);
        step(0, 0, 30'd0, 0, 32'h0, 0, 30'd0, 0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
